// File: rtl/p4_router_trtcm_policer.sv
// Multi-instance token-bucket policer: per-policer single-rate or two-rate three-color marking.
// One-cycle latency; result register stalls intake while a result waits on res_ready.
module p4_router_trtcm_policer #(
  parameter int NUM_POLICERS    = 32,
  parameter int META_WIDTH      = 28,
  parameter int LEN_BITS        = 14,
  parameter int RATE_WHOLE_BITS = 3,
  parameter int FRAC_BITS       = 13,
  parameter int DEPTH_BITS      = 20
) (
  input  logic                            clk,
  input  logic                            aresetn,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic [$clog2(NUM_POLICERS)-1:0] req_policer_id,
  input  logic [LEN_BITS-1:0]             req_byte_length,
  input  logic [META_WIDTH-1:0]           req_meta,
  output logic                            res_valid,
  input  logic                            res_ready,
  output logic [1:0]                      res_color,
  output logic                            res_drop_mark,
  output logic [META_WIDTH-1:0]           res_meta,
  input  logic                            cfg_wr_en,
  input  logic [$clog2(NUM_POLICERS)-1:0] cfg_policer_id,
  input  logic [2:0]                      cfg_sel,
  input  logic [31:0]                     cfg_wdata
);

  localparam int ID_W   = $clog2(NUM_POLICERS);
  localparam int RATE_W = RATE_WHOLE_BITS + FRAC_BITS;
  localparam int BKT_W  = DEPTH_BITS + FRAC_BITS;

  typedef logic [BKT_W-1:0] bkt_t;
  typedef logic [BKT_W:0]   sum_t;
  typedef enum logic [1:0] {GREEN = 2'd0, YELLOW = 2'd1, RED = 2'd2} color_e;

  logic [RATE_W-1:0]     cir  [NUM_POLICERS];
  logic [RATE_W-1:0]     pir  [NUM_POLICERS];
  logic [DEPTH_BITS-1:0] cbs  [NUM_POLICERS];
  logic [DEPTH_BITS-1:0] pbs  [NUM_POLICERS];
  logic                  mode [NUM_POLICERS];
  bkt_t                  tc   [NUM_POLICERS];
  bkt_t                  tp   [NUM_POLICERS];
  logic [ID_W-1:0]       refill_ptr;

  logic                  accept;
  logic [DEPTH_BITS-1:0] len_ext;
  bkt_t                  len_bkt;
  logic                  tc_short, tp_short;
  logic                  take_c, take_p, ded_c, ded_p;
  color_e                color;
  logic [RATE_W+ID_W-1:0] cir_inc, pir_inc;
  bkt_t                  tc_base, tp_base, tc_cap, tp_cap, tc_next, tp_next;
  sum_t                  tc_sum, tp_sum;
  logic                  unused_cfg_bits;

  assign req_ready       = !res_valid || res_ready;
  assign accept          = req_valid && req_ready;
  assign unused_cfg_bits = ^cfg_wdata;

  // Decisions compare whole bytes only; the fraction never grants a packet.
  assign len_ext  = DEPTH_BITS'(req_byte_length);
  assign len_bkt  = {len_ext, {FRAC_BITS{1'b0}}};
  assign tc_short = tc[req_policer_id][BKT_W-1:FRAC_BITS] < len_ext;
  assign tp_short = tp[req_policer_id][BKT_W-1:FRAC_BITS] < len_ext;

  always_comb begin
    color  = GREEN;
    take_c = 1'b0;
    take_p = 1'b0;
    if (req_byte_length != '0) begin
      if (!mode[req_policer_id]) begin
        if (tc_short) color = RED;
        else          take_c = 1'b1;
      end else if (tp_short) begin
        color = RED;
      end else begin
        take_p = 1'b1;
        if (tc_short) color = YELLOW;
        else          take_c = 1'b1;
      end
    end
  end

  assign ded_c = accept && take_c;
  assign ded_p = accept && take_p;

  // Sweep refill; a deduction landing on the swept policer is folded in before saturation.
  always_comb begin
    cir_inc = {cir[refill_ptr], {ID_W{1'b0}}};
    pir_inc = {pir[refill_ptr], {ID_W{1'b0}}};
    tc_cap  = {cbs[refill_ptr], {FRAC_BITS{1'b0}}};
    tp_cap  = {pbs[refill_ptr], {FRAC_BITS{1'b0}}};
    tc_base = tc[refill_ptr];
    tp_base = tp[refill_ptr];
    if (ded_c && req_policer_id == refill_ptr) tc_base = tc_base - len_bkt;
    if (ded_p && req_policer_id == refill_ptr) tp_base = tp_base - len_bkt;
    tc_sum  = sum_t'(tc_base) + sum_t'(cir_inc);
    tp_sum  = sum_t'(tp_base) + sum_t'(pir_inc);
    tc_next = (tc_sum > sum_t'(tc_cap)) ? tc_cap : tc_sum[BKT_W-1:0];
    tp_next = (tp_sum > sum_t'(tp_cap)) ? tp_cap : tp_sum[BKT_W-1:0];
  end

  // Later assignments win: deduction, then refill, then a depth-write bucket load.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      refill_ptr <= '0;
      for (int i = 0; i < NUM_POLICERS; i++) begin
        cir[i]  <= '0;
        pir[i]  <= '0;
        cbs[i]  <= '0;
        pbs[i]  <= '0;
        mode[i] <= 1'b0;
        tc[i]   <= '0;
        tp[i]   <= '0;
      end
    end else begin
      refill_ptr <= refill_ptr + ID_W'(1);
      if (ded_c) tc[req_policer_id] <= tc[req_policer_id] - len_bkt;
      if (ded_p) tp[req_policer_id] <= tp[req_policer_id] - len_bkt;
      tc[refill_ptr] <= tc_next;
      tp[refill_ptr] <= tp_next;
      if (cfg_wr_en) begin
        case (cfg_sel)
          3'd0: cir[cfg_policer_id] <= cfg_wdata[RATE_W-1:0];
          3'd1: begin
            cbs[cfg_policer_id] <= cfg_wdata[DEPTH_BITS-1:0];
            tc[cfg_policer_id]  <= {cfg_wdata[DEPTH_BITS-1:0], {FRAC_BITS{1'b0}}};
          end
          3'd2: pir[cfg_policer_id] <= cfg_wdata[RATE_W-1:0];
          3'd3: begin
            pbs[cfg_policer_id] <= cfg_wdata[DEPTH_BITS-1:0];
            tp[cfg_policer_id]  <= {cfg_wdata[DEPTH_BITS-1:0], {FRAC_BITS{1'b0}}};
          end
          3'd4:    mode[cfg_policer_id] <= cfg_wdata[0];
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      res_valid     <= 1'b0;
      res_color     <= 2'd0;
      res_drop_mark <= 1'b0;
      res_meta      <= '0;
    end else if (accept) begin
      res_valid     <= 1'b1;
      res_color     <= color;
      res_drop_mark <= (color == RED);
      res_meta      <= req_meta;
    end else if (res_ready) begin
      res_valid     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_p4_router_trtcm_policer.sv
// Bench for p4_router_trtcm_policer: directed vector table, multi-cycle corner sequences,
// and a random phase scored against a byte-level bucket model.
module tb_p4_router_trtcm_policer;
  localparam int  N   = 32;
  localparam int  IDW = 5;
  localparam int  MW  = 28;
  localparam int  LB  = 14;
  localparam longint SC = 64'd8192;

  logic          clk = 1'b0;
  logic          aresetn = 1'b0;
  logic          req_valid = 1'b0, req_ready;
  logic [IDW-1:0] req_policer_id = '0;
  logic [LB-1:0] req_byte_length = '0;
  logic [MW-1:0] req_meta = '0;
  logic          res_valid, res_ready = 1'b1;
  logic [1:0]    res_color;
  logic          res_drop_mark;
  logic [MW-1:0] res_meta;
  logic          cfg_wr_en = 1'b0;
  logic [IDW-1:0] cfg_policer_id = '0;
  logic [2:0]    cfg_sel = '0;
  logic [31:0]   cfg_wdata = '0;

  p4_router_trtcm_policer dut (
    .clk(clk), .aresetn(aresetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_policer_id(req_policer_id),
    .req_byte_length(req_byte_length), .req_meta(req_meta),
    .res_valid(res_valid), .res_ready(res_ready), .res_color(res_color),
    .res_drop_mark(res_drop_mark), .res_meta(res_meta),
    .cfg_wr_en(cfg_wr_en), .cfg_policer_id(cfg_policer_id), .cfg_sel(cfg_sel),
    .cfg_wdata(cfg_wdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;

  // Model state: buckets in 1/8192-byte units, rates in 1/8192 byte per clock.
  longint m_tc[N], m_tp[N], m_cir[N], m_pir[N], m_cbs[N], m_pbs[N];
  bit     m_mode[N];
  int     m_ptr;
  bit     m_valid;
  int     m_color;
  longint m_meta;

  typedef struct {
    int id;
    int len;
    int meta;
    int color;
  } vec_t;
  vec_t tbl[13];

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint lmin(input longint a, input longint b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_tc[i] = 0; m_tp[i] = 0; m_cir[i] = 0; m_pir[i] = 0;
      m_cbs[i] = 0; m_pbs[i] = 0; m_mode[i] = 0;
    end
    m_ptr = 0; m_valid = 0; m_color = 0; m_meta = 0;
  endtask

  task automatic model_step();
    bit acc;
    int id, col, p;
    longint b, dc, dp;
    acc = req_valid && (!m_valid || res_ready);
    id  = int'(req_policer_id);
    b   = longint'(req_byte_length);
    dc = 0; dp = 0; col = 0;
    if (acc && b != 0) begin
      if (!m_mode[id]) begin
        if (m_tc[id] / SC < b) col = 2; else dc = b;
      end else if (m_tp[id] / SC < b) begin
        col = 2;
      end else begin
        dp = b;
        if (m_tc[id] / SC < b) col = 1; else dc = b;
      end
    end
    m_tc[id] -= dc * SC;
    m_tp[id] -= dp * SC;
    p = m_ptr;
    m_tc[p] = lmin(m_tc[p] + m_cir[p] * N, m_cbs[p] * SC);
    m_tp[p] = lmin(m_tp[p] + m_pir[p] * N, m_pbs[p] * SC);
    if (cfg_wr_en) begin
      id = int'(cfg_policer_id);
      case (cfg_sel)
        3'd0: m_cir[id] = longint'(cfg_wdata) % 65536;
        3'd1: begin m_cbs[id] = longint'(cfg_wdata) % (1 << 20); m_tc[id] = m_cbs[id] * SC; end
        3'd2: m_pir[id] = longint'(cfg_wdata) % 65536;
        3'd3: begin m_pbs[id] = longint'(cfg_wdata) % (1 << 20); m_tp[id] = m_pbs[id] * SC; end
        3'd4: m_mode[id] = cfg_wdata[0];
        default: ;
      endcase
    end
    if (acc) begin
      m_valid = 1; m_color = col; m_meta = longint'(req_meta);
    end else if (res_ready) begin
      m_valid = 0;
    end
    m_ptr = (m_ptr + 1) % N;
  endtask

  task automatic cmp_out();
    chk("req_ready", req_ready, !m_valid || res_ready);
    chk("res_valid", res_valid, m_valid);
    if (m_valid) begin
      chk("res_color", res_color, m_color);
      chk("res_drop_mark", res_drop_mark, m_color == 2);
      chk("res_meta", res_meta, m_meta);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    cmp_out();
  endtask

  task automatic do_reset();
    @(negedge clk);
    aresetn = 1'b0;
    req_valid = 1'b0; cfg_wr_en = 1'b0; res_ready = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    aresetn = 1'b1;
  endtask

  task automatic cfg(input int id, input int sel, input int unsigned data);
    cfg_wr_en = 1'b1; cfg_policer_id = IDW'(id); cfg_sel = 3'(sel); cfg_wdata = data;
    step();
    cfg_wr_en = 1'b0;
  endtask

  task automatic req(input int id, input int len, input int meta);
    req_valid = 1'b1; req_policer_id = IDW'(id); req_byte_length = LB'(len); req_meta = MW'(meta);
    step();
    req_valid = 1'b0;
  endtask

  task automatic wait_ptr(input int p);
    for (int k = 0; k < N && m_ptr != p; k++) step();
  endtask

  initial begin
    tbl[0]  = '{3, 600, 'h300, 0};
    tbl[1]  = '{3, 600, 'h301, 2};
    tbl[2]  = '{3, 400, 'h302, 0};
    tbl[3]  = '{3,   1, 'h303, 2};
    tbl[4]  = '{3,   0, 'h304, 0};
    tbl[5]  = '{5,  80, 'h500, 0};
    tbl[6]  = '{5,  80, 'h501, 1};
    tbl[7]  = '{5,  80, 'h502, 1};
    tbl[8]  = '{5,  80, 'h503, 2};
    tbl[9]  = '{5,  20, 'h504, 0};
    tbl[10] = '{5,  41, 'h505, 2};
    tbl[11] = '{5,  40, 'h506, 1};
    tbl[12] = '{5,   1, 'h507, 2};

    do_reset();
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_color", res_color, 0);
    chk("rst_drop_mark", res_drop_mark, 0);
    chk("rst_res_meta", res_meta, 0);
    chk("rst_req_ready", req_ready, 1);

    req(0, 64, 'hABCDEF1);
    chk("unconfigured_red", res_color, 2);
    chk("unconfigured_drop", res_drop_mark, 1);
    chk("unconfigured_meta", res_meta, 'hABCDEF1);

    cfg(3, 1, 1000);
    cfg(5, 1, 100);
    cfg(5, 3, 300);
    cfg(5, 4, 1);
    // Back-to-back vectors: each request sees the previous one's deduction.
    for (int i = 0; i < 13; i++) begin
      req_valid = 1'b1; req_policer_id = IDW'(tbl[i].id);
      req_byte_length = LB'(tbl[i].len); req_meta = MW'(tbl[i].meta);
      step();
      chk("tbl_color", res_color, tbl[i].color);
      chk("tbl_meta", res_meta, tbl[i].meta);
    end
    req_valid = 1'b0;
    step();

    // Policer 7: 1 byte/clk refills +32 bytes once per sweep, capped at CBS.
    cfg(7, 1, 64);
    cfg(7, 0, 32'h2000);
    wait_ptr(8);
    req(7, 64, 'h700);
    chk("p7_drain", res_color, 0);
    repeat (31) step();
    req(7, 33, 'h701);
    chk("p7_one_refill_red", res_color, 2);
    req(7, 32, 'h702);
    chk("p7_one_refill_green", res_color, 0);
    repeat (100) step();
    wait_ptr(10);
    req(7, 64, 'h703);
    chk("p7_sat_green", res_color, 0);
    req(7, 1, 'h704);
    chk("p7_sat_cap", res_color, 2);

    // Same-cycle depth write and request: decision on old Tc, load wins afterwards.
    cfg_wr_en = 1'b1; cfg_policer_id = IDW'(9); cfg_sel = 3'd1; cfg_wdata = 500;
    req_valid = 1'b1; req_policer_id = IDW'(9); req_byte_length = LB'(200); req_meta = MW'('h900);
    step();
    cfg_wr_en = 1'b0; req_valid = 1'b0;
    chk("p9_old_red", res_color, 2);
    req(9, 500, 'h901);
    chk("p9_loaded_green", res_color, 0);
    for (int s = 5; s < 8; s++) cfg(9, s, 32'hFFFF_FFFF);
    req(9, 1, 'h902);
    chk("p9_sel_ignored", res_color, 2);

    // Backpressure: result held, intake stalled, pending request follows release.
    req(0, 0, 'h111);
    res_ready = 1'b0;
    req_valid = 1'b1; req_policer_id = '0; req_byte_length = '0; req_meta = MW'('h222);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("bp_req_ready", req_ready, 0);
      chk("bp_hold_meta", res_meta, 'h111);
    end
    res_ready = 1'b1;
    step();
    req_valid = 1'b0;
    chk("bp_next_meta", res_meta, 'h222);
    chk("bp_next_valid", res_valid, 1);
    step();

    for (int p = 16; p < 20; p++) begin
      cfg(p, 0, $urandom_range(0, 65535));
      cfg(p, 1, $urandom_range(0, 4000));
      cfg(p, 2, $urandom_range(0, 65535));
      cfg(p, 3, $urandom_range(0, 6000));
      cfg(p, 4, $urandom_range(0, 1));
    end
    for (int c = 0; c < 1500; c++) begin
      req_valid       = ($urandom_range(0, 9) < 7);
      req_policer_id  = IDW'(16 + $urandom_range(0, 3));
      req_byte_length = ($urandom_range(0, 7) == 0) ? '0 : LB'($urandom_range(1, 1200));
      req_meta        = MW'($urandom);
      res_ready       = ($urandom_range(0, 3) != 0);
      cfg_wr_en       = ($urandom_range(0, 49) == 0);
      cfg_policer_id  = IDW'(16 + $urandom_range(0, 3));
      cfg_sel         = 3'($urandom_range(0, 7));
      cfg_wdata       = $urandom_range(0, 65535) ^ ($urandom & 32'hFFF0_0000);
      step();
    end
    req_valid = 1'b0; cfg_wr_en = 1'b0; res_ready = 1'b1;
    step();

    // Reset with a result in flight drops it and clears configuration.
    res_ready = 1'b0;
    req(16, 1, 'h1234);
    chk("inflight_valid", res_valid, 1);
    aresetn = 1'b0;
    #1;
    chk("reset_drops_result", res_valid, 0);
    do_reset();
    req(16, 1, 'h1235);
    chk("post_reset_red", res_color, 2);
    step();

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule

// File: doc/p4_router_trtcm_policer.md
# p4_router_trtcm_policer

Multi-instance token-bucket policer for the P4 router queue system, sitting between the VNP4 wrapper output and congestion management. Generalises the single-rate CIR/CBS drop-mark policer to NUM_POLICERS independent instances, each selectable at run time between single-rate two-color and two-rate three-color (RFC 2698, color-blind) modes. Each request produces a 2-bit color and a policer drop mark, with the caller's metadata carried through alongside.

## Interface
Parameters:
- NUM_POLICERS, 32, policer instances; power of two, 2..256
- META_WIDTH, 28, pass-through metadata width (vnp4_wrapper_metadata_t)
- LEN_BITS, 14, packet byte-length width
- RATE_WHOLE_BITS, 3, whole bytes/clk of CIR/PIR
- FRAC_BITS, 13, fractional bits of rates and buckets
- DEPTH_BITS, 20, CBS/PBS width in bytes

Ports:
- clk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- req_valid  in  1  request valid
- req_ready  out  1  request ready; equals !res_valid || res_ready
- req_policer_id  in  $clog2(NUM_POLICERS)  policer index
- req_byte_length  in  LEN_BITS  packet bytes B
- req_meta  in  META_WIDTH  metadata, passed through unchanged
- res_valid  out  1  result valid
- res_ready  in  1  result accepted
- res_color  out  2  0 green, 1 yellow, 2 red
- res_drop_mark  out  1  res_color==red
- res_meta  out  META_WIDTH  req_meta of the evaluated request
- cfg_wr_en  in  1  config write strobe
- cfg_policer_id  in  $clog2(NUM_POLICERS)  target policer
- cfg_sel  in  3  0 CIR, 1 CBS, 2 PIR, 3 PBS, 4 MODE; 5-7 ignored
- cfg_wdata  in  32  CIR/PIR: {whole,frac} in low RATE_WHOLE_BITS+FRAC_BITS bits; CBS/PBS: low DEPTH_BITS bits; MODE: bit0 (0 single-rate, 1 trTCM)

## Operation
- Per-policer state, all in flops: CIR, PIR, CBS, PBS, mode, Tc, Tp. Buckets are DEPTH_BITS.FRAC_BITS unsigned.
- Refill sweep: refill_ptr increments modulo NUM_POLICERS every cycle, free-running. The visited policer gets Tc=min(Tc+CIR·NUM_POLICERS, CBS.0) and Tp=min(Tp+PIR·NUM_POLICERS, PBS.0). The multiply is a left shift by log2(NUM_POLICERS); the adder is one bit wider than the bucket, then saturates.
- Request is accepted on req_valid&&req_ready. Buckets are compared on whole bits only, using pre-update values.
- Single-rate mode:
  - Tc<B: red.
  - Otherwise green, Tc-=B.
  - Tp is untouched apart from refill.
- trTCM mode:
  - Tp<B: red, no deduction.
  - Otherwise, Tc<B: yellow, Tp-=B.
  - Otherwise green, Tp-=B and Tc-=B.
- B=0 is always green with no change.
- Refill and deduction on the same policer in the same cycle: new=min(old−deduct+inc, cap). The decision still uses old.
- Config writes take effect the next cycle.
  - A CBS write also sets Tc=CBS.0; a PBS write also sets Tp=PBS.0.
  - If the write hits the same policer as an accepted request in the same cycle, the request is evaluated on the old values. The bucket load from a CBS/PBS write overrides that request's deduction and refill.
  - CIR, PIR and MODE writes do not alter buckets.
- cfg_sel 5-7 is ignored. Writes are never stalled.

## Timing
- Reset (asynchronous assert, synchronous deassert expected upstream) sets:
  - all rates, depths, modes, buckets and refill_ptr to 0
  - res_valid=0, res_color=0, res_drop_mark=0, res_meta=0
- req_ready=1 out of reset.
- With all config at 0, every B>0 request is red.
- Latency is 1 cycle: a request accepted at edge n gives res_valid=1 after edge n.
- Output register holds while res_valid&&!res_ready, and req_ready=0 in that case.
- Back-to-back requests to the same policer at full rate see each other's deduction, with no hazard window.
- Reset mid-stream drops the in-flight result.

## Test plan
- Reset, request policer 0 with B=64 → red, drop_mark=1, res_meta echoed.
- NUM_POLICERS=32, policer 3 single-rate: CBS=1000, CIR=0. Requests B=600 then B=600 → green then red; Tc ends at 400.
- policer 5 trTCM: CBS=100, PBS=300, CIR=PIR=0. B=80, 80, 80, 80 → green, yellow, yellow, red; final Tp=60, Tc=20.
- policer 7 single-rate: CBS=64, CIR=1.0 byte/clk. Drain with B=64, then idle 32 cycles → exactly one refill of +32 is observed. After 64 cycles idle, Tc saturates at 64; the next B=64 is green.
- Backpressure: hold res_ready=0 for 5 cycles with req_valid=1 → req_ready=0 and outputs are stable. After release, the queued result is followed next cycle by the pending request.
- Same-cycle CBS=500 write and B=200 request on policer 9 with Tc=0 → red, then Tc=500 (load overrides).
